// File: rtl/frequency_generator.sv
// Square-wave stimulus source: emits tens*10+units rising edges per window of
// UPDATE_PERIOD clocks, spread evenly by a DDA accumulator. New digit values
// are converted serially and committed only on window boundaries.
module frequency_generator #(
    parameter int UPDATE_PERIOD = 12000,
    parameter int BITS          = 14
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       load,
    output logic       ready,
    output logic       error,
    output logic       signal,
    output logic       window,
    output logic [6:0] target
);

    typedef enum logic [1:0] {IDLE, CONV_TENS, CONV_UNITS} state_t;

    localparam logic [BITS-1:0] LAST_SAMPLE = BITS'(UPDATE_PERIOD - 1);
    localparam logic [BITS:0]   PERIOD      = (BITS + 1)'(UPDATE_PERIOD);

    state_t          r_state;
    state_t          w_next_state;
    logic [BITS-1:0] r_sample;
    logic [BITS:0]   r_acc;
    logic            r_signal;
    logic [6:0]      r_target;
    logic [6:0]      r_pend_target;
    logic            r_pend_valid;
    logic [6:0]      r_conv;
    logic [3:0]      r_tens_left;
    logic [3:0]      r_units;
    logic            r_error;

    logic            w_boundary;
    logic            w_digits_ok;
    logic            w_accept;
    logic [BITS:0]   w_acc_next;
    logic            w_wrap;

    assign w_boundary  = (r_sample == LAST_SAMPLE);
    assign w_digits_ok = (tens <= 4'd9) && (units <= 4'd9);
    assign w_accept    = (r_state == IDLE) && load && w_digits_ok;
    assign w_acc_next  = r_acc + (BITS + 1)'({r_target, 1'b0});
    assign w_wrap      = (w_acc_next >= PERIOD);

    assign window = w_boundary;
    assign signal = r_signal;
    assign target = r_target;
    assign error  = r_error;

    // Window counter: free-running, wraps at UPDATE_PERIOD-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample <= '0;
        end else if (w_boundary) begin
            r_sample <= '0;
        end else begin
            r_sample <= r_sample + BITS'(1);
        end
    end

    // Conversion FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Conversion FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:       if (w_accept) w_next_state = CONV_TENS;
            CONV_TENS:  if (r_tens_left == 4'd0) w_next_state = CONV_UNITS;
            CONV_UNITS: w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Conversion FSM outputs
    always_comb begin
        ready = (r_state == IDLE);
    end

    // Digit capture and repeated-add tens conversion; error pulse on bad digits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conv      <= '0;
            r_tens_left <= '0;
            r_units     <= '0;
            r_error     <= 1'b0;
        end else begin
            r_error <= (r_state == IDLE) && load && !w_digits_ok;
            if (w_accept) begin
                r_tens_left <= tens;
                r_units     <= units;
                r_conv      <= '0;
            end else if (r_state == CONV_TENS && r_tens_left != 4'd0) begin
                r_conv      <= r_conv + 7'd10;
                r_tens_left <= r_tens_left - 4'd1;
            end
        end
    end

    // Pending/commit: boundary commits the old pending value; a coinciding
    // CONV_UNITS write is ordered last so the new value stays pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_target      <= '0;
            r_pend_target <= '0;
            r_pend_valid  <= 1'b0;
        end else begin
            if (w_boundary && r_pend_valid) begin
                r_target     <= r_pend_target;
                r_pend_valid <= 1'b0;
            end
            if (r_state == CONV_UNITS) begin
                r_pend_target <= r_conv + {3'b000, r_units};
                r_pend_valid  <= 1'b1;
            end
        end
    end

    // DDA: 2*target toggles per window, last one landing on the boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_signal <= 1'b0;
        end else if (w_wrap) begin
            r_acc    <= w_acc_next - PERIOD;
            r_signal <= ~r_signal;
        end else begin
            r_acc    <= w_acc_next;
        end
    end

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator: a short-window instance (200 clocks)
// for most scenarios and a full-size instance (12000 clocks) for the 1-edge case.
module tb_frequency_generator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] tens_a, units_a, tens_b, units_b;
    logic       load_a, load_b;
    logic       ready_a, error_a, signal_a, window_a;
    logic       ready_b, error_b, signal_b, window_b;
    logic [6:0] target_a, target_b;

    int checks = 0;
    int errors = 0;
    int t = 0;   // clocks since reset release == expected window sample

    always #5 clk = ~clk;

    frequency_generator #(.UPDATE_PERIOD(200), .BITS(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .tens(tens_a), .units(units_a), .load(load_a),
        .ready(ready_a), .error(error_a), .signal(signal_a), .window(window_a), .target(target_a)
    );

    frequency_generator #(.UPDATE_PERIOD(12000), .BITS(14)) dut_b (
        .clk(clk), .reset_n(reset_n), .tens(tens_b), .units(units_b), .load(load_b),
        .ready(ready_b), .error(error_b), .signal(signal_b), .window(window_b), .target(target_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic align(input int period, input int k);
        int n = 0;
        while ((t % period) != k && n < 2 * period) begin
            tick();
            n++;
        end
    endtask

    task automatic do_load_a(input logic [3:0] tt, input logic [3:0] uu, output int lowcnt);
        tens_a = tt; units_a = uu; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        lowcnt = 0;
        while (ready_a == 1'b0 && lowcnt < 100) begin
            lowcnt++;
            tick();
        end
    endtask

    task automatic count_window_a(output int rises, output int maxgap, output logic sig_end);
        logic prev;
        int last;
        prev = signal_a; last = -1; rises = 0; maxgap = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (!prev && signal_a) begin
                if (last >= 0 && (i - last) > maxgap) maxgap = i - last;
                last = i;
                rises++;
            end
            prev = signal_a;
        end
        sig_end = signal_a;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        t = 0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (ready_a !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
        checks++; if (target_a !== 7'd0)  begin errors++; $display("FAIL reset_target: got %0d expected 0", target_a); end
        checks++; if (signal_a !== 1'b0)  begin errors++; $display("FAIL reset_signal: got %b expected 0", signal_a); end
        checks++; if (error_a !== 1'b0)   begin errors++; $display("FAIL reset_error: got %b expected 0", error_a); end
        checks++; if (window_a !== 1'b0)  begin errors++; $display("FAIL reset_window: got %b expected 0", window_a); end
        checks++; if (ready_b !== 1'b1)   begin errors++; $display("FAIL reset_ready_b: got %b expected 1", ready_b); end
        release_reset();
    endtask

    task automatic test_window();
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++;
            if (window_a !== ((t % 200) == 199)) begin
                errors++; $display("FAIL window_decode: t=%0d got %b expected %b", t, window_a, (t % 200) == 199);
            end
        end
    endtask

    task automatic test_one_edge();
        int n, ones, first;
        align(12000, 10);
        tens_b = 4'd0; units_b = 4'd1; load_b = 1'b1;
        tick();
        load_b = 1'b0;
        n = 0;
        while (ready_b == 1'b0 && n < 100) begin n++; tick(); end
        checks++; if (n != 2) begin errors++; $display("FAIL one_ready_low: got %0d expected 2", n); end
        align(12000, 0);
        checks++; if (target_b !== 7'd1) begin errors++; $display("FAIL one_target: got %0d expected 1", target_b); end
        ones = 0; first = -1;
        for (int i = 0; i < 12000; i++) begin
            if (signal_b) begin ones++; if (first < 0) first = i; end
            if (i == 11999) begin
                checks++; if (window_b !== 1'b1) begin errors++; $display("FAIL one_window: got %b expected 1", window_b); end
            end
            tick();
        end
        checks++; if (ones != 6000)  begin errors++; $display("FAIL one_high_cycles: got %0d expected 6000", ones); end
        checks++; if (first != 6000) begin errors++; $display("FAIL one_first_high: got %0d expected 6000", first); end
        checks++; if (signal_b !== 1'b0) begin errors++; $display("FAIL one_fall_boundary: got %b expected 0", signal_b); end
    endtask

    task automatic test_load_99();
        int n, rises, gap;
        logic se;
        align(200, 20);
        do_load_a(4'd9, 4'd9, n);
        checks++; if (n != 11) begin errors++; $display("FAIL l99_ready_low: got %0d expected 11", n); end
        align(200, 0);
        checks++; if (target_a !== 7'd99) begin errors++; $display("FAIL l99_target: got %0d expected 99", target_a); end
        for (int w = 0; w < 2; w++) begin
            count_window_a(rises, gap, se);
            checks++; if (rises != 99) begin errors++; $display("FAIL l99_rises: got %0d expected 99", rises); end
            checks++; if (gap > 3)     begin errors++; $display("FAIL l99_gap: got %0d expected <=3", gap); end
            checks++; if (se !== 1'b0) begin errors++; $display("FAIL l99_boundary_low: got %b expected 0", se); end
        end
    endtask

    task automatic test_last_wins();
        int n, rises, gap;
        logic se;
        align(200, 10);
        do_load_a(4'd4, 4'd2, n);
        do_load_a(4'd1, 4'd7, n);
        checks++; if (n != 3) begin errors++; $display("FAIL lw_ready_low: got %0d expected 3", n); end
        checks++; if (target_a !== 7'd99) begin errors++; $display("FAIL lw_before_commit: got %0d expected 99", target_a); end
        align(200, 0);
        checks++; if (target_a !== 7'd17) begin errors++; $display("FAIL lw_target: got %0d expected 17", target_a); end
        count_window_a(rises, gap, se);
        checks++; if (rises != 17) begin errors++; $display("FAIL lw_rises: got %0d expected 17", rises); end
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL lw_boundary_low: got %b expected 0", se); end
    endtask

    task automatic test_error();
        int n;
        align(200, 10);
        do_load_a(4'd10, 4'd3, n);
        checks++; if (n != 0)         begin errors++; $display("FAIL err_ready: got %0d low cycles expected 0", n); end
        checks++; if (error_a !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b expected 1", error_a); end
        tick();
        checks++; if (error_a !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", error_a); end
        do_load_a(4'd2, 4'd12, n);
        checks++; if (error_a !== 1'b1) begin errors++; $display("FAIL err_units: got %b expected 1", error_a); end
        align(200, 0);
        checks++; if (target_a !== 7'd17) begin errors++; $display("FAIL err_target_kept: got %0d expected 17", target_a); end
    endtask

    task automatic test_load_ignored();
        align(200, 10);
        tens_a = 4'd5; units_a = 4'd0; load_a = 1'b1;
        tick();
        tens_a = 4'd3; units_a = 4'd3;
        tick();
        checks++; if (error_a !== 1'b0) begin errors++; $display("FAIL ign_no_error1: got %b expected 0", error_a); end
        tens_a = 4'd12; units_a = 4'd3;
        tick();
        checks++; if (error_a !== 1'b0) begin errors++; $display("FAIL ign_no_error2: got %b expected 0", error_a); end
        load_a = 1'b0;
        tick();
        checks++; if (error_a !== 1'b0) begin errors++; $display("FAIL ign_no_error3: got %b expected 0", error_a); end
        align(200, 0);
        checks++; if (target_a !== 7'd50) begin errors++; $display("FAIL ign_target: got %0d expected 50", target_a); end
    endtask

    task automatic test_collision();
        int n;
        align(200, 5);
        do_load_a(4'd2, 4'd1, n);
        // 3/3 loaded in the cycle with sample 194 reaches CONV_UNITS at sample 199
        align(200, 194);
        tens_a = 4'd3; units_a = 4'd3; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        align(200, 0);
        checks++; if (target_a !== 7'd21) begin errors++; $display("FAIL col_old_commit: got %0d expected 21", target_a); end
        checks++; if (ready_a !== 1'b1)   begin errors++; $display("FAIL col_ready: got %b expected 1", ready_a); end
        tick();
        align(200, 0);
        checks++; if (target_a !== 7'd33) begin errors++; $display("FAIL col_new_commit: got %0d expected 33", target_a); end
    endtask

    task automatic test_reset_mid();
        int n;
        align(200, 10);
        do_load_a(4'd4, 4'd2, n);
        align(200, 0);
        checks++; if (target_a !== 7'd42) begin errors++; $display("FAIL rm_target_pre: got %0d expected 42", target_a); end
        align(200, 50);
        tens_a = 4'd5; units_a = 4'd0; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (target_a !== 7'd0)  begin errors++; $display("FAIL rm_target: got %0d expected 0", target_a); end
        checks++; if (signal_a !== 1'b0)  begin errors++; $display("FAIL rm_signal: got %b expected 0", signal_a); end
        checks++; if (ready_a !== 1'b1)   begin errors++; $display("FAIL rm_ready: got %b expected 1", ready_a); end
        checks++; if (target_b !== 7'd0)  begin errors++; $display("FAIL rm_target_b: got %0d expected 0", target_b); end
        release_reset();
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++;
            if (window_a !== ((t % 200) == 199)) begin
                errors++; $display("FAIL rm_window: t=%0d got %b expected %b", t, window_a, (t % 200) == 199);
            end
        end
        checks++; if (target_a !== 7'd0) begin errors++; $display("FAIL rm_pending_lost: got %0d expected 0", target_a); end
    endtask

    initial begin
        reset_n = 1'b0;
        tens_a = '0; units_a = '0; load_a = 1'b0;
        tens_b = '0; units_b = '0; load_b = 1'b0;
        test_reset();
        test_window();
        test_one_edge();
        test_load_99();
        test_last_wins();
        test_error();
        test_load_ignored();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
